// File: rtl/ram8_arbiter.sv
// Two-requester round-robin front end for a single-port ram8 (8 x 16).
// Each transaction takes three cycles: a grant in IDLE, one SERVE cycle, then one ACK pulse.
module ram8_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  addr0,
    input  logic [2:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [2:0]  mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic [1:0]  state_dbg
);

    // Handshake: a requester holds req (level) until it sees its one-cycle ack;
    // req/we/addr/wdata are sampled only at the grant edge, and a req still high
    // after the ack is taken as a fresh transaction.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   gnt_id;
    logic   sel_id;

    // Requester 1 wins when it is alone, or when both ask and prio favours it.
    assign sel_id    = (req0 && req1) ? prio : req1;
    assign state_dbg = state;

    // The latched transaction lives directly in the mem_* registers, so the
    // ram8 sees a stable address/data/load for the whole SERVE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            gnt_id      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= 16'h0000;
            rdata1      <= 16'h0000;
            mem_address <= 3'd0;
            mem_in      <= 16'h0000;
            mem_load    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        gnt_id      <= sel_id;
                        mem_address <= sel_id ? addr1  : addr0;
                        mem_in      <= sel_id ? wdata1 : wdata0;
                        mem_load    <= sel_id ? we1    : we0;
                        state       <= SERVE;
                    end
                end
                SERVE: begin
                    // mem_out still shows the pre-write word at this edge.
                    if (gnt_id) begin
                        rdata1 <= mem_out;
                    end else begin
                        rdata0 <= mem_out;
                    end
                    prio        <= ~gnt_id;
                    ack0        <= ~gnt_id;
                    ack1        <= gnt_id;
                    mem_address <= 3'd0;
                    mem_in      <= 16'h0000;
                    mem_load    <= 1'b0;
                    state       <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    mem_address <= 3'd0;
                    mem_in      <= 16'h0000;
                    mem_load    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  addr0 = 3'd0, addr1 = 3'd0;
    logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
    logic        ack0, ack1, mem_load;
    logic [15:0] rdata0, rdata1, mem_in, mem_out;
    logic [2:0]  mem_address;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    ram8_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
        .mem_out(mem_out), .state_dbg(state_dbg)
    );

    // ram8 behaviour: combinational read, write on rising edge when load=1.
    logic [15:0] ram [8] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
    end
    assign mem_out = ram[mem_address];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    // One requester, one transaction from IDLE; returns the captured rdata.
    task automatic single_txn(input logic id, input logic we, input logic [2:0] a,
                              input logic [15:0] d, output logic [15:0] rd);
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("txn_ack", id ? ack1 : ack0, 16'd1);
        rd = id ? rdata1 : rdata0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic r0, r1, w0, w1;
        logic [2:0] a0, a1;
        logic [15:0] d0, d1;
        logic gid;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t vecs[8];

    // Reference model state (transaction level).
    int          m_busy;
    logic        m_prio, m_id, m_we;
    logic [2:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] shadow [8];
    logic        known [8];
    logic [15:0] e_rd [2];
    logic        rd_known [2];
    logic        e_ack [2];
    logic        e_load;
    logic [2:0]  e_addr;
    logic [15:0] e_in;

    task automatic model_step();
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_load = 1'b0; e_addr = 3'd0; e_in = 16'h0;
        if (m_busy == 0) begin
            if (req0 || req1) begin
                m_id    = (req0 && req1) ? m_prio : req1;
                m_we    = m_id ? we1 : we0;
                m_addr  = m_id ? addr1 : addr0;
                m_wdata = m_id ? wdata1 : wdata0;
                e_load = m_we; e_addr = m_addr; e_in = m_wdata;
                m_busy = 1;
            end
        end else if (m_busy == 1) begin
            rd_known[m_id] = known[m_addr];
            e_rd[m_id]     = shadow[m_addr];
            if (known[m_addr]) exp_q.push_back(shadow[m_addr]);
            if (m_we) begin
                shadow[m_addr] = m_wdata;
                known[m_addr]  = 1'b1;
            end
            m_prio = ~m_id;
            e_ack[m_id] = 1'b1;
            m_busy = 2;
        end else begin
            m_busy = 0;
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] got_q[$];
        int loads;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd3, 16'h0001, 16'h0000, 1'b1, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h1234};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 16'h0000, 16'hBEEF, 1'b1, 16'h0000, 16'h0001};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 3'd2, 16'h0000, 16'h7777, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0000};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ack0", ack0, 16'd0);
        check("rst_ack1", ack1, 16'd0);
        check("rst_rdata0", rdata0, 16'h0);
        check("rst_rdata1", rdata1, 16'h0);
        check("rst_mem_load", mem_load, 16'd0);
        check("rst_mem_address", mem_address, 16'd0);
        check("rst_mem_in", mem_in, 16'h0);
        check("rst_state", state_dbg, 16'd0);
        reset = 1'b0;

        // Directed vector table, one transaction per entry.
        for (int i = 0; i < 8; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            @(negedge clk);
            check("vec_serve_addr", mem_address, vecs[i].gid ? vecs[i].a1 : vecs[i].a0);
            check("vec_serve_load", mem_load, vecs[i].gid ? vecs[i].w1 : vecs[i].w0);
            check("vec_serve_in", mem_in, vecs[i].gid ? vecs[i].d1 : vecs[i].d0);
            check("vec_serve_noack", {ack1, ack0}, 16'd0);
            idle_inputs();
            addr0 = 3'($urandom); addr1 = 3'($urandom);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            @(negedge clk);
            check("vec_ack0", ack0, 16'(!vecs[i].gid));
            check("vec_ack1", ack1, 16'(vecs[i].gid));
            check("vec_rdata0", rdata0, vecs[i].e0);
            check("vec_rdata1", rdata1, vecs[i].e1);
            check("vec_ack_load", mem_load, 16'd0);
            @(negedge clk);
            check("vec_idle_ack", {ack1, ack0}, 16'd0);
            check("vec_idle_state", state_dbg, 16'd0);
        end

        // Contention from reset with both reqs held: acks 0,1,0,1,0.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd6; wdata0 = 16'hC0DE;
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd6; wdata1 = 16'h5A5A;
        exp_q = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
        got_q = {};
        loads = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("hold_both_acks", 16'(ack0 & ack1), 16'd0);
            if (ack0) got_q.push_back(16'd0);
            if (ack1) got_q.push_back(16'd1);
            if (mem_load) begin
                loads++;
                check("hold_load_addr", mem_address, 16'd6);
                check("hold_load_in", mem_in, 16'hC0DE);
            end
            if (c == 2)  check("hold_first_ack0", ack0, 16'd1);
            if (c == 5)  begin
                check("hold_first_ack1", ack1, 16'd1);
                check("hold_read_after_write", rdata1, 16'hC0DE);
            end
            if (c == 13) idle_inputs();
        end
        check("hold_load_cycles", 16'(loads), 16'd3);
        check("hold_ack_count", 16'(got_q.size()), 16'(exp_q.size()));
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) check("hold_ack_order", got_q[k], exp_q[k]);
        end
        check("hold_rdata0", rdata0, 16'hC0DE);
        exp_q = {};

        // Input change during SERVE must not redirect the access.
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h2222;
        @(negedge clk);
        check("chg_serve_addr", mem_address, 16'd2);
        check("chg_serve_in", mem_in, 16'h2222);
        addr1 = 3'd7; wdata1 = 16'hFFFF; req1 = 1'b0;
        @(negedge clk);
        check("chg_ack1", ack1, 16'd1);
        check("chg_old_value", rdata1, 16'h0000);
        @(negedge clk);
        single_txn(1'b1, 1'b0, 3'd7, 16'h0, rd);
        check("chg_addr7_untouched", rd, 16'h0000);
        single_txn(1'b1, 1'b0, 3'd2, 16'h0, rd);
        check("chg_addr2_written", rd, 16'h2222);

        // Reset mid-SERVE aborts the write.
        single_txn(1'b0, 1'b1, 3'd4, 16'h5555, rd);
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd4; wdata0 = 16'hAAAA;
        @(negedge clk);
        check("abort_serve_load", mem_load, 16'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_load_drop", mem_load, 16'd0);
        check("abort_addr_zero", mem_address, 16'd0);
        check("abort_state_idle", state_dbg, 16'd0);
        idle_inputs();
        @(negedge clk);
        check("abort_no_ack", {ack1, ack0}, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_still_no_ack", {ack1, ack0}, 16'd0);
        single_txn(1'b0, 1'b0, 3'd4, 16'h0, rd);
        check("abort_addr4_kept", rd, 16'h5555);

        // Randomized traffic against the reference model.
        do_reset();
        m_busy = 0; m_prio = 1'b0; m_id = 1'b0; m_we = 1'b0; m_addr = 3'd0; m_wdata = 16'h0;
        for (int k = 0; k < 8; k++) begin shadow[k] = 16'h0; known[k] = 1'b0; end
        e_rd[0] = 16'h0; e_rd[1] = 16'h0; rd_known[0] = 1'b1; rd_known[1] = 1'b1;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_load = 1'b0; e_addr = 3'd0; e_in = 16'h0;
        exp_q = {};
        for (int n = 0; n < 900; n++) begin
            check("rnd_ack0", ack0, 16'(e_ack[0]));
            check("rnd_ack1", ack1, 16'(e_ack[1]));
            check("rnd_load", mem_load, 16'(e_load));
            check("rnd_addr", mem_address, 16'(e_addr));
            check("rnd_in", mem_in, e_in);
            if (rd_known[0]) check("rnd_rdata0", rdata0, e_rd[0]);
            if (rd_known[1]) check("rnd_rdata1", rdata1, e_rd[1]);
            if ((ack0 || ack1) && (rd_known[ack1]) && exp_q.size() > 0)
                check("rnd_scoreboard", ack1 ? rdata1 : rdata0, exp_q.pop_front());
            req0 = 1'($urandom_range(0, 2) != 0);
            req1 = 1'($urandom_range(0, 2) != 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            addr0 = 3'($urandom_range(0, 7));
            addr1 = 3'($urandom_range(0, 7));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            model_step();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/ram8_arbiter.md
RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 SHALL have no parameters; data width is fixed at 16 and address width at 3, matching the ram8 ports.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 req0, req1  input  1 each  transaction request from requester 0 or 1; level, sampled only in IDLE.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualifies the matching req.
REQ-006 addr0, addr1  input  3 each  target word address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the matching requester.
REQ-009 rdata0, rdata1  output  16 each  registered read data; holds its value until that requester's next ack.
REQ-010 mem_address  output  3  drives ram8 address.
REQ-011 mem_in  output  16  drives ram8 in.
REQ-012 mem_load  output  1  drives ram8 load; ram8 writes on the rising clk edge when load=1.
REQ-013 mem_out  input  16  ram8 out (combinational read of mem_address).

Function
REQ-014 SHALL implement the FSM states IDLE, SERVE and ACK, with a 1-bit round-robin pointer prio (0 = requester 0 favoured).
REQ-015 IDLE: if only one req is high, SHALL grant that requester.
REQ-016 IDLE: if both reqs are high, SHALL grant the requester indicated by prio.
REQ-017 IDLE, on grant: SHALL latch the grantee id, we, addr and wdata into internal registers, then go to SERVE.
REQ-018 IDLE, no req high: SHALL remain in IDLE.
REQ-019 SERVE lasts exactly 1 cycle: mem_address=latched addr, mem_in=latched wdata, mem_load=latched we.
REQ-020 At the SERVE->ACK edge, SHALL capture mem_out into the grantee's rdata, so rdata is the word value before any write in that cycle.
REQ-021 At the SERVE->ACK edge, SHALL set prio to the id of the requester NOT just served.
REQ-022 ACK lasts exactly 1 cycle: ack of the grantee =1, other ack=0, mem_load=0; then go to IDLE.
REQ-023 Latency: req sampled at edge N -> ack high during cycle N+2 -> next grant possible at edge N+3; throughput is 1 transaction per 3 cycles.
REQ-024 Outside SERVE: mem_load=0, mem_address=0, mem_in=0.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.
REQ-026 Changes to req, we, addr or wdata after the grant edge SHALL NOT affect the transaction in flight.
REQ-027 A req still high in IDLE after its ack SHALL be treated as a new transaction; with both reqs held continuously, grants SHALL alternate 0,1,0,1.
REQ-028 The rdata of the requester that was not served SHALL remain unchanged.

Reset
REQ-029 While reset=1, asynchronously: state=IDLE, prio=0, ack0=ack1=0, rdata0=rdata1=0, mem_load=0, mem_address=0, mem_in=0.
REQ-030 Reset asserted during SERVE SHALL abort the transaction; no ram8 write occurs and no ack is issued.
REQ-031 First grant after reset release SHALL be evaluated at the first rising edge with reset=0.

Verification
REQ-032 Write then read, requester 0: req0,we0=1,addr0=3,wdata0=16'h1234, then a read of addr 3 -> rdata0=16'h1234 with ack0 pulse 2 cycles after each grant.
REQ-033 Contention from reset: req0 and req1 both high at the same edge -> requester 0 served first, requester 1 acked 3 cycles later, prio=0 afterwards.
REQ-034 Both reqs held for 4 transactions -> ack order 0,1,0,1; never both acks high; mem_load high only in SERVE cycles with we=1.
REQ-035 Write-read semantics: write addr 5 value 16'hBEEF over old value 16'h0001 -> rdata of that write = 16'h0001; a subsequent read of addr 5 = 16'hBEEF.
REQ-036 Input change after grant: change addr1 from 2 to 7 during SERVE -> the access goes to address 2 only.
REQ-037 Reset pulse mid-SERVE of write 16'hAAAA to addr 4 -> mem_load drops immediately, addr 4 keeps its old value, no ack, FSM in IDLE.
